// File: rtl/serial_subtractor8.sv
// Bit-serial subtractor: Diff = A - B - Bin, one bit per clock LSB first,
// through a single full-subtractor cell and a borrow flip-flop.
module serial_subtractor8 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             busy,
  output logic             done
);

  // state  | meaning
  // IDLE   | waiting for start
  // SHIFT  | one result bit per cycle, WIDTH cycles
  // DONE   | Diff/Bout just updated, done pulse
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] res_nxt;
  logic             borrow;
  logic             borrow_nxt;
  logic             bit_d;
  logic [CW-1:0]    cnt;
  logic             last_bit;
  logic             load;

  assign bit_d      = a_sr[0] ^ b_sr[0] ^ borrow;
  assign borrow_nxt = (~a_sr[0] & b_sr[0]) | (~a_sr[0] & borrow) | (b_sr[0] & borrow);
  assign res_nxt    = {bit_d, res_sr[WIDTH-1:1]};
  assign last_bit   = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A start seen on the DONE exit edge is taken directly so that a held
  // start yields one result every WIDTH+1 cycles.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (last_bit) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = ST_SHIFT;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
    end else if (load) begin
      a_sr   <= A;
      b_sr   <= B;
      res_sr <= '0;
      borrow <= Bin;
      cnt    <= '0;
    end else if (state == ST_SHIFT) begin
      a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
      res_sr <= res_nxt;
      borrow <= borrow_nxt;
      cnt    <= cnt + CW'(1);
    end
  end

  // Result registers move only on the edge that enters DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Diff <= '0;
      Bout <= 1'b0;
    end else if (state == ST_SHIFT && last_bit) begin
      Diff <= res_nxt;
      Bout <= borrow_nxt;
    end
  end

  assign busy = (state == ST_SHIFT);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_serial_subtractor8.sv
// Scoreboard bench for serial_subtractor8 at WIDTH=8 and WIDTH=16; expected
// results come from plain integer subtraction.
module tb_serial_subtractor8;

  logic        clk = 1'b0;
  logic        clk_en = 1'b0;
  logic        rst_n = 1'b1;

  logic        start8 = 1'b0;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic        bin8 = 1'b0;
  logic [7:0]  diff8;
  logic        bout8, busy8, done8;

  logic        start16 = 1'b0;
  logic [15:0] a16 = '0;
  logic [15:0] b16 = '0;
  logic        bin16 = 1'b0;
  logic [15:0] diff16;
  logic        bout16, busy16, done16;

  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    int unsigned cyc;
    logic [15:0] diff;
    logic        bout;
  } exp_t;

  exp_t sb8[$];
  exp_t sb16[$];

  serial_subtractor8 #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .A(a8), .B(b8), .Bin(bin8),
    .Diff(diff8), .Bout(bout8), .busy(busy8), .done(done8)
  );

  serial_subtractor8 #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .A(a16), .B(b16), .Bin(bin16),
    .Diff(diff16), .Bout(bout16), .busy(busy16), .done(done16)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference: unsigned subtraction as an integer; borrow is a negative result.
  function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                 input logic bin, input int unsigned acc);
    exp_t e;
    int   r;
    r      = int'(a) - int'(b) - int'(bin);
    e.cyc  = acc + w;
    e.bout = (r < 0);
    e.diff = 16'(r & ((1 << w) - 1));
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done8) begin
      checks++;
      if (sb8.size() == 0) begin
        errors++;
        $display("FAIL w8_unexpected_done actual diff=%0h bout=%0b required no done at cycle %0d",
                 diff8, bout8, cyc);
      end else begin
        e = sb8.pop_front();
        if (diff8 !== e.diff[7:0] || bout8 !== e.bout || cyc !== e.cyc || busy8 !== 1'b0) begin
          errors++;
          $display("FAIL w8_result actual diff=%0h bout=%0b cyc=%0d busy=%0b required diff=%0h bout=%0b cyc=%0d busy=0",
                   diff8, bout8, cyc, busy8, e.diff[7:0], e.bout, e.cyc);
        end
      end
    end
    if (rst_n && done16) begin
      checks++;
      if (sb16.size() == 0) begin
        errors++;
        $display("FAIL w16_unexpected_done actual diff=%0h bout=%0b required no done at cycle %0d",
                 diff16, bout16, cyc);
      end else begin
        e = sb16.pop_front();
        if (diff16 !== e.diff || bout16 !== e.bout || cyc !== e.cyc || busy16 !== 1'b0) begin
          errors++;
          $display("FAIL w16_result actual diff=%0h bout=%0b cyc=%0d busy=%0b required diff=%0h bout=%0b cyc=%0d busy=0",
                   diff16, bout16, cyc, busy16, e.diff, e.bout, e.cyc);
        end
      end
    end
  end

  // One 8-bit operation; returns one cycle after DONE with done checked low.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic bin);
    start8 = 1'b1; a8 = a; b8 = b; bin8 = bin;
    tick();
    sb8.push_back(model(8, 16'(a), 16'(b), bin, cyc));
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
    repeat (9) tick();
    chk("w8_done_drop", 32'(done8), 32'd0);
  endtask

  initial begin
    int unsigned k;
    #5 rst_n = 1'b0;
    #5;
    chk("reset_w8_outputs", 32'({diff8, bout8, busy8, done8}), 32'd0);
    chk("reset_w16_outputs", 32'({diff16, bout16, busy16, done16}), 32'd0);
    #2 clk_en = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_w8_outputs", 32'({diff8, bout8, busy8, done8}), 32'd0);
    end
    chk("idle_w16_outputs", 32'({diff16, bout16, busy16, done16}), 32'd0);

    // start during SHIFT is ignored; Diff holds the reset value until DONE
    start8 = 1'b1; a8 = 8'h50; b8 = 8'h20; bin8 = 1'b0;
    tick();
    k = cyc;
    sb8.push_back(model(8, 16'h50, 16'h20, 1'b0, k));
    start8 = 1'b0;
    chk("ign_diff_hold", 32'(diff8), 32'd0);
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk("ign_diff_hold", 32'(diff8), 32'd0);
      chk("ign_busy", 32'(busy8), 32'd1);
      if (i == 2) begin
        start8 = 1'b1; a8 = 8'h01; b8 = 8'h01;
      end
      if (i == 3) begin
        start8 = 1'b0; a8 = 8'hFF; b8 = 8'hAA;
      end
    end
    repeat (12) tick();

    // basic subtraction with busy/done timing
    start8 = 1'b1; a8 = 8'h50; b8 = 8'h20; bin8 = 1'b0;
    tick();
    k = cyc;
    sb8.push_back(model(8, 16'h50, 16'h20, 1'b0, k));
    start8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("basic_busy", 32'(busy8), 32'd1);
      chk("basic_no_done", 32'(done8), 32'd0);
      tick();
    end
    chk("basic_done", 32'(done8), 32'd1);
    chk("basic_diff", 32'(diff8), 32'h30);
    chk("basic_bout", 32'(bout8), 32'd0);
    tick();
    chk("basic_done_drop", 32'(done8), 32'd0);

    run8(8'h00, 8'h01, 1'b0);
    chk("borrow_00_01", 32'({bout8, diff8}), 32'h1FF);
    run8(8'h80, 8'h7F, 1'b1);
    chk("borrow_80_7f", 32'({bout8, diff8}), 32'h000);
    run8(8'hFF, 8'hFF, 1'b1);
    chk("borrow_ff_ff", 32'({bout8, diff8}), 32'h1FF);

    // back-to-back with start held high
    start8 = 1'b1; a8 = 8'h10; b8 = 8'h03; bin8 = 1'b0;
    tick();
    k = cyc;
    sb8.push_back(model(8, 16'h10, 16'h03, 1'b0, k));
    a8 = 8'h03; b8 = 8'h10;
    repeat (9) tick();
    sb8.push_back(model(8, 16'h03, 16'h10, 1'b0, k + 9));
    start8 = 1'b0;
    chk("b2b_busy_second", 32'(busy8), 32'd1);
    repeat (8) tick();
    chk("b2b_second", 32'({bout8, diff8}), 32'h1F3);
    tick();
    chk("b2b_done_drop", 32'(done8), 32'd0);

    // reset mid-operation
    start8 = 1'b1; a8 = 8'h50; b8 = 8'h20; bin8 = 1'b0;
    tick();
    start8 = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_outputs", 32'({diff8, bout8, busy8, done8}), 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (12) tick();
    chk("midrst_no_result", 32'({diff8, bout8, done8}), 32'd0);
    run8(8'h09, 8'h04, 1'b0);
    chk("midrst_after", 32'(diff8), 32'h05);

    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          logic [7:0] ra, rb;
          logic       rbin;
          ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
          start8 = 1'b1; a8 = ra; b8 = rb; bin8 = rbin;
          tick();
          sb8.push_back(model(8, 16'(ra), 16'(rb), rbin, cyc));
          start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
          repeat (8) tick();
          repeat ($urandom_range(0, 2)) tick();
        end
      end
      begin
        for (int i = 0; i < 1000; i++) begin
          logic [15:0] ra, rb;
          logic        rbin;
          ra = 16'($urandom); rb = 16'($urandom); rbin = 1'($urandom);
          if (i % 8 == 0) rb = ra;
          start16 = 1'b1; a16 = ra; b16 = rb; bin16 = rbin;
          tick();
          sb16.push_back(model(16, ra, rb, rbin, cyc));
          start16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
          repeat (16) tick();
          repeat ($urandom_range(0, 2)) tick();
        end
      end
    join

    repeat (20) tick();
    chk("w8_sb_drained", 32'(sb8.size()), 32'd0);
    chk("w16_sb_drained", 32'(sb16.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
